alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have one clock and one reset; the reset is synchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: start  input  1  request strobe, sampled only in IDLE.
REQ-005 Port: op  input  2  operation: 00 ADD, 01 SUB, 10 NOT, 11 MUL.
REQ-006 Port: a  input  4  operand A, captured on accept.
REQ-007 Port: b  input  4  operand B, captured on accept; ignored for NOT.
REQ-008 Port: busy  output  1  high from the cycle after accept through the done cycle, inclusive.
REQ-009 Port: done  output  1  one-cycle pulse when result is valid.
REQ-010 Port: result  output  4  registered result, modulo 16.

Function
REQ-011 Accept SHALL occur on edge k when state is IDLE and start=1; a, b and op are registered at that edge.
REQ-012 States SHALL be IDLE, ADD1, SUB1, SUB2, NOT1, MUL0..MUL3 and DONE.
REQ-013 All additions SHALL use one shared 4-bit adder instance; all inversions SHALL use one 4-bit inverter instance.
REQ-014 ADD SHALL register result=a+b at edge k+1 (latency 1).
REQ-015 NOT SHALL register result=~a at edge k+1 (latency 1).
REQ-016 SUB pass 1 SHALL register the partial sum a+~b at edge k+1.
REQ-017 SUB pass 2 SHALL register result=partial+1 at edge k+2 (latency 2).
REQ-018 MUL SHALL clear the accumulator at accept.
REQ-019 At MULi (i=0..3), edges k+1..k+4, MUL SHALL add (a<<i) truncated to 4 bits when b[i]=1, else hold the accumulator.
REQ-020 MUL SHALL register result=acc at edge k+4 (latency 4).
REQ-021 done SHALL be high for exactly the one cycle following the final-result edge; the state then returns to IDLE.
REQ-022 busy SHALL fall with done.
REQ-023 A start accepted on the edge ending the done cycle SHALL be honoured, giving back-to-back operation.
REQ-024 start SHALL be ignored while busy=1; the operands held internally SHALL not change.
REQ-025 result SHALL hold its last value until the next operation's final-result edge.
REQ-026 Intermediate values SHALL NOT appear on result.
REQ-027 All arithmetic SHALL wrap modulo 16; no carry or overflow output exists.

Reset
REQ-028 rst=1 at any edge SHALL force IDLE and set busy=0, done=0, result=0 and the accumulator and operand registers to 0.
REQ-029 Reset mid-operation SHALL abort the operation with no done pulse.
REQ-030 start asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-031 The op encodings and the state enumeration SHALL reside in the shared package alu_pkg.
REQ-032 The block SHALL instantiate the existing fulladd4 and inverter4 components.
REQ-033 Operand-select muxes feeding the shared adder SHALL be driven by the current state.
REQ-034 No other sub-module SHALL be used.

Verification
REQ-035 ADD a=7, b=9 -> done at k+1, result=0 (wrap).
REQ-036 SUB a=3, b=5 -> done at k+2, result=14.
REQ-037 NOT a=0xA -> done at k+1, result=5.
REQ-038 MUL a=7, b=6 -> done at k+4, result=10; then MUL a=3, b=5 back-to-back -> result=15.
REQ-039 Start pulsed during MUL1 with ADD a=1, b=1 -> ignored; MUL result unchanged, one done pulse only.
REQ-040 rst at MUL2 -> next cycle IDLE, result=0, busy=0, no done pulse; a subsequent ADD 2+2 -> result=4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: operation codes, FSM states and
// the multiply partial-product helper.
package alu_pkg;

    localparam int W = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_NOT = 2'b10,
        OP_MUL = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADD1,
        S_SUB1,
        S_SUB2,
        S_NOT1,
        S_MUL0,
        S_MUL1,
        S_MUL2,
        S_MUL3,
        S_DONE
    } state_e;

    // First working state entered on accept for each operation.
    function automatic state_e first_state(input op_e op);
        case (op)
            OP_ADD:  return S_ADD1;
            OP_SUB:  return S_SUB1;
            OP_NOT:  return S_NOT1;
            default: return S_MUL0;
        endcase
    endfunction

    // Shift-and-add term for one multiplier bit, truncated to W bits.
    function automatic logic [W-1:0] mul_addend(input logic [W-1:0] a,
                                                input logic           b_bit,
                                                input logic [1:0]     shift);
        return b_bit ? (a << shift) : '0;
    endfunction

endpackage

// File: rtl/fulladd4.sv
// 4-bit ripple adder with carry in/out; the single shared adder of the sequencer.
module fulladd4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
endmodule

// File: rtl/inverter4.sv
// 4-bit bitwise inverter; the single shared inverter of the sequencer.
module inverter4 (
    input  logic [3:0] a,
    output logic [3:0] y
);
    assign y = ~a;
endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle 4-bit ALU: ADD/NOT in one pass, SUB in two, MUL by shift-and-add
// over four passes, all through one shared adder and one shared inverter.
module alu_sequencer
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    state_e       state, next_state;
    logic [W-1:0] a_q, b_q, acc_q, result_q;

    logic [W-1:0] add_x, add_y, add_sum;
    logic         add_cin, add_cout_unused;
    logic [W-1:0] inv_in, inv_out;

    fulladd4 u_add (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout_unused)
    );

    inverter4 u_inv (
        .a (inv_in),
        .y (inv_out)
    );

    assign inv_in = (state == S_NOT1) ? a_q : b_q;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        add_x      = '0;
        add_y      = '0;
        add_cin    = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start)
                    next_state = first_state(op_e'(op));
                else if (state == S_DONE)
                    next_state = S_IDLE;
            end
            S_ADD1: begin
                add_x      = a_q;
                add_y      = b_q;
                next_state = S_DONE;
            end
            S_SUB1: begin
                add_x      = a_q;
                add_y      = inv_out;
                next_state = S_SUB2;
            end
            S_SUB2: begin
                add_x      = acc_q;
                add_cin    = 1'b1;
                next_state = S_DONE;
            end
            S_NOT1: next_state = S_DONE;
            S_MUL0: begin
                add_x      = acc_q;
                add_y      = mul_addend(a_q, b_q[0], 2'd0);
                next_state = S_MUL1;
            end
            S_MUL1: begin
                add_x      = acc_q;
                add_y      = mul_addend(a_q, b_q[1], 2'd1);
                next_state = S_MUL2;
            end
            S_MUL2: begin
                add_x      = acc_q;
                add_y      = mul_addend(a_q, b_q[2], 2'd2);
                next_state = S_MUL3;
            end
            S_MUL3: begin
                add_x      = acc_q;
                add_y      = mul_addend(a_q, b_q[3], 2'd3);
                next_state = S_DONE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state <= next_state;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        acc_q <= '0;
                    end
                end
                S_ADD1, S_SUB2: result_q <= add_sum;
                S_NOT1:         result_q <= inv_out;
                // acc_q doubles as the SUB partial sum and the MUL accumulator.
                S_SUB1, S_MUL0, S_MUL1, S_MUL2: acc_q <= add_sum;
                S_MUL3: begin
                    acc_q    <= add_sum;
                    result_q <= add_sum;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases, randomized operations
// against an arithmetic reference model, start-while-busy and mid-op reset.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [3:0] a, b;
    logic       busy, done;
    logic [3:0] result;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_result;

    alu_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] ref_result(input logic [1:0] o, input logic [3:0] x, y);
        int r;
        case (o)
            2'd0:    r = (int'(x) + int'(y)) % 16;
            2'd1:    r = (int'(x) + 16 - int'(y)) % 16;
            2'd2:    r = 15 - int'(x);
            default: r = (int'(x) * int'(y)) % 16;
        endcase
        return 4'(r);
    endfunction

    function automatic int ref_latency(input logic [1:0] o);
        case (o)
            2'd1:    return 2;
            2'd3:    return 4;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Issue one operation starting now; returns just after the done edge.
    // poke>0 pulses a stray ADD 1+1 start request during working state poke.
    task automatic do_op(input logic [1:0] o, input logic [3:0] x, y, input int poke);
        int         lat;
        logic [3:0] want;
        lat   = ref_latency(o);
        want  = ref_result(o, x, y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 2'($urandom);
        a     = 4'($urandom);
        b     = 4'($urandom);
        check("busy_after_accept", {3'b0, busy}, 4'd1);
        check("done_after_accept", {3'b0, done}, 4'd0);
        for (int j = 1; j < lat; j++) begin
            @(posedge clk); #1;
            start = 1'b0;
            check("busy_working", {3'b0, busy}, 4'd1);
            check("done_working", {3'b0, done}, 4'd0);
            check("result_hold_working", result, exp_result);
            if (j == poke) begin
                start = 1'b1;
                op    = 2'd0;
                a     = 4'd1;
                b     = 4'd1;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("done_pulse", {3'b0, done}, 4'd1);
        check("busy_in_done", {3'b0, busy}, 4'd1);
        check("result_value", result, want);
        exp_result = want;
    endtask

    task automatic check_idle(input string tag);
        @(posedge clk); #1;
        check({tag, "_done"}, {3'b0, done}, 4'd0);
        check({tag, "_busy"}, {3'b0, busy}, 4'd0);
        check({tag, "_result"}, result, exp_result);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b1;
        op         = 2'd0;
        a          = 4'd5;
        b          = 4'd5;
        exp_result = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {3'b0, busy}, 4'd0);
        check("reset_done", {3'b0, done}, 4'd0);
        check("reset_result", result, 4'd0);
        rst   = 1'b0;
        start = 1'b0;
        check_idle("after_reset");

        do_op(2'd0, 4'd7, 4'd9, 0);   // ADD wrap -> 0
        check_idle("add_idle");
        do_op(2'd1, 4'd3, 4'd5, 0);   // SUB -> 14
        check_idle("sub_idle");
        do_op(2'd2, 4'hA, 4'd3, 0);   // NOT -> 5
        check_idle("not_idle");
        do_op(2'd3, 4'd7, 4'd6, 0);   // MUL -> 10
        do_op(2'd3, 4'd3, 4'd5, 0);   // back-to-back MUL -> 15
        check_idle("mul_b2b_idle");
        do_op(2'd3, 4'd7, 4'd6, 1);   // stray start during MUL1 ignored
        check_idle("poke_idle");
        check_idle("poke_idle2");

        for (int n = 0; n < 40; n++) begin
            do_op(2'($urandom), 4'($urandom), 4'($urandom), 0);
            if ($urandom_range(0, 1) == 1)
                check_idle("rand_idle");
        end
        check_idle("rand_end_idle");

        // Reset while in MUL2 aborts with no done pulse.
        start = 1'b1;
        op    = 2'd3;
        a     = 4'd7;
        b     = 4'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        exp_result = 4'd0;
        check("midop_reset_busy", {3'b0, busy}, 4'd0);
        check("midop_reset_done", {3'b0, done}, 4'd0);
        check("midop_reset_result", result, 4'd0);
        for (int n = 0; n < 4; n++)
            check_idle("post_reset");
        do_op(2'd0, 4'd2, 4'd2, 0);   // ADD -> 4
        check_idle("final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
